// File: rtl/menshen_cfg_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_REQ configuration AXI streams
// onto one Menshen config path, with a programmable settle gap after each packet.
module menshen_cfg_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 30
) (
    input  logic                          axis_aclk,
    input  logic                          axis_rst,
    input  logic [NUM_REQ-1:0]            cfg_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_cfg_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_cfg_tvalid,
    output logic [NUM_REQ-1:0]            s_axis_cfg_tready,
    input  logic [NUM_REQ-1:0]            s_axis_cfg_tlast,
    input  logic [NUM_REQ*6-1:0]          s_axis_cfg_tuser_mty,
    input  logic [NUM_REQ*11-1:0]         s_axis_cfg_tuser_qid,
    output logic [DATA_WIDTH-1:0]         m_axis_cfg_tdata,
    output logic                          m_axis_cfg_tvalid,
    input  logic                          m_axis_cfg_tready,
    output logic                          m_axis_cfg_tlast,
    output logic [5:0]                    m_axis_cfg_tuser_mty,
    output logic [10:0]                   m_axis_cfg_tuser_qid,
    output logic [NUM_REQ-1:0]            cfg_grant,
    output logic                          cfg_busy,
    output logic [31:0]                   cfg_pkt_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;

    logic [NUM_REQ-1:0] req;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               xfer;
    logic               last_fire;

    assign xfer      = (state_q == XFER);
    assign last_fire = m_axis_cfg_tvalid & m_axis_cfg_tready & m_axis_cfg_tlast;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        req   = s_axis_cfg_tvalid & cfg_en;
        found = 1'b0;
        pick  = last_grant_q;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Zero-latency mux of the granted slice; everything reads as 0 without a grant.
    always_comb begin
        m_axis_cfg_tdata     = '0;
        m_axis_cfg_tvalid    = 1'b0;
        m_axis_cfg_tlast     = 1'b0;
        m_axis_cfg_tuser_mty = '0;
        m_axis_cfg_tuser_qid = '0;
        s_axis_cfg_tready    = '0;
        if (xfer) begin
            m_axis_cfg_tdata          = s_axis_cfg_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_cfg_tvalid         = s_axis_cfg_tvalid[gidx_q];
            m_axis_cfg_tlast          = s_axis_cfg_tlast[gidx_q];
            m_axis_cfg_tuser_mty      = s_axis_cfg_tuser_mty[int'(gidx_q)*6 +: 6];
            m_axis_cfg_tuser_qid      = s_axis_cfg_tuser_qid[int'(gidx_q)*11 +: 11];
            s_axis_cfg_tready[gidx_q] = m_axis_cfg_tready;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        gap_d        = gap_q;
        pkt_cnt_d    = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = NUM_REQ'(1) << pick;
                    gidx_d       = pick;
                    last_grant_d = pick;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (last_fire) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    grant_d   = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = CNT_W'(GAP_CYCLES);
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - CNT_W'(1);
                if (gap_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset seeds last_grant with the top index so requester 0 wins first.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gidx_q       <= '0;
            grant_q      <= '0;
            gap_q        <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gidx_q       <= gidx_d;
            grant_q      <= grant_d;
            gap_q        <= gap_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign cfg_grant   = grant_q;
    assign cfg_busy    = (state_q != IDLE);
    assign cfg_pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/menshen_cfg_arbiter.md
# menshen_cfg_arbiter

Packet-atomic round-robin arbiter that shares the single Menshen configuration AXI-stream path between `NUM_REQ` configuration sources, for example per-QID host configuration queues. It sits on the `axis_aclk` domain, in front of the packet-filter configuration input of the user box. It grants one complete configuration packet at a time and enforces a programmable idle gap after each packet, so the pipeline's stage-configuration writes settle before the next packet is accepted.

## Interface
- `DATA_WIDTH`, 512: tdata width of every stream.
- `NUM_REQ`, 2: number of requesters; range 2–8.
- `GAP_CYCLES`, 30: idle cycles forced after each granted packet's last beat; 0 means no gap.

Ports:
- `axis_aclk`  in  1  the only clock.
- `axis_rst`  in  1  asynchronous, active-high reset.
- `cfg_en`  in  NUM_REQ  per-requester enable; sampled only at grant time.
- `s_axis_cfg_tdata`  in  NUM_REQ*DATA_WIDTH  requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_cfg_tvalid`  in  NUM_REQ  per-requester valid.
- `s_axis_cfg_tready`  out  NUM_REQ  per-requester ready.
- `s_axis_cfg_tlast`  in  NUM_REQ  per-requester last.
- `s_axis_cfg_tuser_mty`  in  NUM_REQ*6  empty-byte count of the last beat.
- `s_axis_cfg_tuser_qid`  in  NUM_REQ*11  source queue id.
- `m_axis_cfg_tdata`  out  DATA_WIDTH  granted data.
- `m_axis_cfg_tvalid`  out  1  granted valid.
- `m_axis_cfg_tready`  in  1  downstream ready.
- `m_axis_cfg_tlast`  out  1  granted last.
- `m_axis_cfg_tuser_mty`  out  6  granted mty.
- `m_axis_cfg_tuser_qid`  out  11  granted qid.
- `cfg_grant`  out  NUM_REQ  one-hot current grant; 0 when no grant is held.
- `cfg_busy`  out  1  high in XFER or GAP.
- `cfg_pkt_cnt`  out  32  count of completed packets.

## Operation
- State machine with three states: IDLE, XFER, GAP.
- **IDLE**
  - The request vector is `s_axis_cfg_tvalid & cfg_en`.
  - If it is nonzero, the registered grant is set to the first requesting index, searching `last_grant+1` upward with wrap modulo NUM_REQ. `last_grant` is then updated, and the state moves to XFER.
  - If no request is present, the state stays IDLE.
- **XFER**
  - The granted requester is combinationally muxed to the `m_axis` outputs.
  - `s_axis_cfg_tready[g] = m_axis_cfg_tready`; every other tready is 0.
  - A beat transfers when `m_axis_cfg_tvalid & m_axis_cfg_tready`.
  - When the transferred beat has tlast: `cfg_pkt_cnt` increments (wrapping at 2^32), the grant clears, and the next state is GAP with the counter loaded to GAP_CYCLES. If GAP_CYCLES = 0, the next state is IDLE.
- **GAP**
  - The counter decrements once per cycle. At 1 → IDLE.
  - All treadies are 0 and `m_axis_cfg_tvalid` is 0.
- `cfg_en` falling mid-packet has no effect; the packet completes.
- The outputs do not check that mty is 0 on non-last beats. mty and qid pass through unchanged.
- A requester dropping tvalid mid-packet is allowed. `m_axis_cfg_tvalid` follows it low, and the grant is held until tlast.
- `cfg_busy = (state != IDLE)`.

## Timing
- Reset values:
  - state IDLE, `last_grant` = NUM_REQ-1 (requester 0 wins first), gap counter 0.
  - `cfg_grant` 0, `cfg_pkt_cnt` 0, `cfg_busy` 0.
  - `m_axis_cfg_tvalid` 0, all `s_axis_cfg_tready` 0.
  - `m_axis_cfg_tdata`, `m_axis_cfg_tlast`, `m_axis_cfg_tuser_mty` and `m_axis_cfg_tuser_qid` are driven 0 whenever no grant is held.
- Arbitration latency: a request first seen in IDLE at edge N is granted at edge N+1. Its first beat can transfer in the cycle after edge N+1.
- Datapath latency is zero: the `m_axis` side is a combinational mux of the granted slice. There is no buffering, so backpressure propagates in the same cycle.
- Packet-to-packet spacing from the last-beat edge to the earliest next-packet first-beat transfer is GAP_CYCLES+2 cycles; with GAP_CYCLES = 0 it is 2 cycles.
- `cfg_pkt_cnt` updates on the edge that accepts tlast.
- Asserting `axis_rst` mid-packet immediately clears all state and outputs. The partial packet is abandoned and is not counted; downstream sees a truncated packet.
- Simultaneous requests are resolved only in IDLE. A request arriving during XFER or GAP waits.

## Test plan
- **Single requester.** Reset; after reset release, requester 0 sends a 3-beat packet with mty 0, 0, 6'b000100 and qid 0.
  - Grant 0b01 one cycle after the request is seen.
  - Three beats out unchanged.
  - `cfg_pkt_cnt` = 1; `cfg_busy` low GAP_CYCLES+1 cycles after tlast.
- **Round-robin fairness.** Both requesters continuously valid with 1-beat packets (qid 0 and qid 2).
  - Output qid sequence is 0, 2, 0, 2.
  - First-beat spacing is GAP_CYCLES+2 cycles.
- **Backpressure.** `m_axis_cfg_tready` low for 5 cycles mid-packet.
  - `s_axis_cfg_tready[g]` is low for the same cycles.
  - No beat is lost or duplicated, and the data order is preserved.
- **Enable mask.** `cfg_en` = 2'b10 with both requesting: only requester 1 is granted.
  - Then clear `cfg_en[1]` during its packet: the packet completes and no further grant is issued.
- **Gap = 0 variant.** Parameter GAP_CYCLES = 0: back-to-back 1-beat packets from requester 0 transfer every 2 cycles.
- **Reset mid-packet.** Assert `axis_rst` on beat 2 of 4.
  - `m_axis_cfg_tvalid`, `cfg_grant` and `cfg_pkt_cnt` are 0 immediately.
  - After release, requester 0 wins first.
